universal_shift_register: RTL and testbench

UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

---
 rtl/universal_shift_register.sv | 90 +++++++++
 tb/tb_universal_shift_register.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/universal_shift_register.sv
`default_nettype none
// ---------------------------------------------------------------------------
// universal_shift_register: hold / shift right / shift left / load register
// with a saturating count of shifts since the last load or reset.
// Define USR_ROTATE_EN to rotate instead of taking sin_r / sin_l.
// Revision: 1.0
// ---------------------------------------------------------------------------
module universal_shift_register #(
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [1:0]                   mode,
  input  logic [WIDTH-1:0]             d,
  input  logic                         sin_r,
  input  logic                         sin_l,
  output logic [WIDTH-1:0]             q,
  output logic                         sout_r,
  output logic                         sout_l,
  output logic [$clog2(WIDTH+1)-1:0]   shift_cnt,
  output logic                         full
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] C_CNT_MAX = CW'(WIDTH);

  localparam logic [1:0] C_MODE_HOLD  = 2'b00;
  localparam logic [1:0] C_MODE_RIGHT = 2'b01;
  localparam logic [1:0] C_MODE_LEFT  = 2'b10;
  localparam logic [1:0] C_MODE_LOAD  = 2'b11;

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic             ser_r, ser_l;

`ifdef USR_ROTATE_EN
  // Serial inputs stay on the port list in both builds; rotation ignores them.
  logic unused_sin;
  assign unused_sin = sin_r ^ sin_l;
  assign ser_r = q_q[0];
  assign ser_l = q_q[WIDTH-1];
`else
  assign ser_r = sin_r;
  assign ser_l = sin_l;
`endif

  assign cnt_inc = (cnt_q == C_CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    q_d   = q_q;
    cnt_d = cnt_q;
    if (en) begin
      case (mode)
        C_MODE_HOLD: ;
        C_MODE_RIGHT: begin
          q_d   = {ser_r, q_q[WIDTH-1:1]};
          cnt_d = cnt_inc;
        end
        C_MODE_LEFT: begin
          q_d   = {q_q[WIDTH-2:0], ser_l};
          cnt_d = cnt_inc;
        end
        C_MODE_LOAD: begin
          q_d   = d;
          cnt_d = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= '0;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  assign q         = q_q;
  assign sout_r    = q_q[0];
  assign sout_l    = q_q[WIDTH-1];
  assign shift_cnt = cnt_q;
  assign full      = (cnt_q == C_CNT_MAX);

endmodule
`default_nettype wire

// File: tb/tb_universal_shift_register.sv
`default_nettype none
// Directed-vector bench for universal_shift_register (WIDTH = 8); expected
// register state is queued per cycle and checked by an independent monitor.
module tb_universal_shift_register;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [7:0] d;
  logic       sin_r;
  logic       sin_l;
  logic [7:0] q;
  logic       sout_r;
  logic       sout_l;
  logic [3:0] shift_cnt;
  logic       full;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] q;
    logic [3:0] cnt;
    string      tag;
  } exp_t;

  exp_t sb[$];

  universal_shift_register #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .d        (d),
    .sin_r    (sin_r),
    .sin_l    (sin_l),
    .q        (q),
    .sout_r   (sout_r),
    .sout_l   (sout_l),
    .shift_cnt(shift_cnt),
    .full     (full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: each post-edge sample consumes one queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.tag, ".q"},      q,                 e.q);
        check({e.tag, ".cnt"},    {4'h0, shift_cnt}, {4'h0, e.cnt});
        check({e.tag, ".full"},   {7'h0, full},      {7'h0, (e.cnt == 4'd8)});
        check({e.tag, ".sout_r"}, {7'h0, sout_r},    {7'h0, e.q[0]});
        check({e.tag, ".sout_l"}, {7'h0, sout_l},    {7'h0, e.q[7]});
      end
    end
  end

  task automatic step(input string tag, input logic r, input logic e, input logic [1:0] m,
                      input logic [7:0] dd, input logic sr, input logic sl,
                      input logic [7:0] eq, input logic [3:0] ec);
    exp_t x;
    @(negedge clk);
    rst   = r;
    en    = e;
    mode  = m;
    d     = dd;
    sin_r = sr;
    sin_l = sl;
    x.q   = eq;
    x.cnt = ec;
    x.tag = tag;
    sb.push_back(x);
  endtask

  // Drive load/junk data between edges and restore before the next edge.
  task automatic glitch();
    logic [1:0] sm;
    logic [7:0] sd;
    @(posedge clk);
    #2;
    sm = mode;
    sd = d;
    mode = 2'b11;
    d = 8'hFF;
    #1;
    mode = sm;
    d = sd;
  endtask

  initial begin
    int wait_cyc;
    rst = 1'b0; en = 1'b0; mode = 2'b00; d = 8'h00; sin_r = 1'b0; sin_l = 1'b0;
    repeat (2) @(negedge clk);

    step("reset",      1, 0, 2'b00, 8'h00, 0, 0, 8'h00, 4'd0);
    step("load_a5",    0, 1, 2'b11, 8'hA5, 0, 0, 8'hA5, 4'd0);
    step("rst_ovr",    1, 1, 2'b11, 8'hA5, 0, 0, 8'h00, 4'd0);

    step("ld_a5",      0, 1, 2'b11, 8'hA5, 0, 0, 8'hA5, 4'd0);
    step("shr1",       0, 1, 2'b01, 8'h00, 1, 0, 8'hD2, 4'd1);

    step("ld_3c",      0, 1, 2'b11, 8'h3C, 0, 0, 8'h3C, 4'd0);
    for (int i = 0; i < 5; i++) begin
      step("en_gate",  0, 0, 2'b01, 8'h00, 1, 1, 8'h3C, 4'd0);
      glitch();
    end
    step("hold_m0",    0, 1, 2'b00, 8'hFF, 1, 1, 8'h3C, 4'd0);
    glitch();
    step("hold_m0b",   0, 1, 2'b00, 8'h00, 1, 1, 8'h3C, 4'd0);

`ifndef USR_ROTATE_EN
    step("alt_r",      0, 1, 2'b01, 8'h00, 0, 0, 8'h1E, 4'd1);
    step("alt_l",      0, 1, 2'b10, 8'h00, 0, 0, 8'h3C, 4'd2);

    step("ld_81",      0, 1, 2'b11, 8'h81, 0, 0, 8'h81, 4'd0);
    step("ser1",       0, 1, 2'b10, 8'h00, 1, 0, 8'h02, 4'd1);
    step("ser2",       0, 1, 2'b10, 8'h00, 1, 0, 8'h04, 4'd2);
    step("ser3",       0, 1, 2'b10, 8'h00, 1, 0, 8'h08, 4'd3);
    step("ser4",       0, 1, 2'b10, 8'h00, 1, 0, 8'h10, 4'd4);
    step("ser5",       0, 1, 2'b10, 8'h00, 1, 0, 8'h20, 4'd5);
    step("ser6",       0, 1, 2'b10, 8'h00, 1, 0, 8'h40, 4'd6);
    step("ser7",       0, 1, 2'b10, 8'h00, 1, 0, 8'h80, 4'd7);
    step("ser8",       0, 1, 2'b10, 8'h00, 1, 0, 8'h00, 4'd8);
    step("sat_shl",    0, 1, 2'b10, 8'h00, 0, 1, 8'h01, 4'd8);
    step("sat_shr",    0, 1, 2'b01, 8'h00, 1, 0, 8'h80, 4'd8);
    step("sat_hold",   0, 0, 2'b10, 8'h00, 0, 1, 8'h80, 4'd8);

    step("ld_ff",      0, 1, 2'b11, 8'hFF, 0, 0, 8'hFF, 4'd0);
    step("mid_sh1",    0, 1, 2'b10, 8'h00, 0, 0, 8'hFE, 4'd1);
    step("mid_sh2",    0, 1, 2'b10, 8'h00, 0, 0, 8'hFC, 4'd2);
    step("mid_sh3",    0, 1, 2'b10, 8'h00, 0, 0, 8'hF8, 4'd3);
    step("mid_rst",    1, 1, 2'b10, 8'h00, 0, 1, 8'h00, 4'd0);
    step("post_rst",   0, 1, 2'b10, 8'h00, 0, 1, 8'h01, 4'd1);
`else
    step("rot_ld01",   0, 1, 2'b11, 8'h01, 0, 0, 8'h01, 4'd0);
    step("rot_r",      0, 1, 2'b01, 8'h00, 0, 1, 8'h80, 4'd1);
    step("rot_l",      0, 1, 2'b10, 8'h00, 1, 0, 8'h01, 4'd2);
    step("rot_ld81",   0, 1, 2'b11, 8'h81, 0, 0, 8'h81, 4'd0);
    step("rot_l2",     0, 1, 2'b10, 8'h00, 0, 0, 8'h03, 4'd1);
    step("rot_r2",     0, 1, 2'b01, 8'h00, 0, 0, 8'h81, 4'd2);
`endif

    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
